// File: rtl/tff_mod_counter.sv
`default_nettype none
// ============================================================================
// Module   : tff_mod_counter
// Brief    : WIDTH-bit toggle-based register with per-bit toggle, modulo
//            up/down count, saturating parallel load, terminal-count pulse
//            and sticky overflow flag.
// Revision : 1.0 - initial release
// ============================================================================
module tff_mod_counter #(
   parameter int WIDTH     = 4,
   parameter int MODULUS   = 16,
   parameter int RESET_VAL = 0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic             up_dn,
   input  logic [WIDTH-1:0] t_vec,
   input  logic [WIDTH-1:0] load_val,
   input  logic             ovf_clr,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             ovf
);

   localparam logic [1:0] c_mode_hold   = 2'b00;
   localparam logic [1:0] c_mode_count  = 2'b01;
   localparam logic [1:0] c_mode_toggle = 2'b10;
   localparam logic [1:0] c_mode_load   = 2'b11;

   // Top of the count range; MODULUS-1 always fits in WIDTH bits.
   localparam logic [WIDTH-1:0] c_max   = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH-1:0] c_reset = WIDTH'(RESET_VAL);

   logic [WIDTH-1:0] r_q;
   logic             r_tc;
   logic             r_ovf;

   logic [WIDTH-1:0] w_q_next;
   logic             w_wrap;
   logic             w_q_oor;
   logic             w_load_oor;

   // With a full-range modulus no value can lie above c_max, so the
   // out-of-range detectors collapse to constant zero.
   generate
      if (MODULUS == (1 << WIDTH)) begin : g_full_range
         assign w_q_oor    = 1'b0;
         assign w_load_oor = 1'b0;
      end else begin : g_partial_range
         assign w_q_oor    = (r_q > c_max);
         assign w_load_oor = (load_val > c_max);
      end
   endgenerate

   // Next-state selection and wrap detection for the current mode.
   always_comb begin
      w_q_next = r_q;
      w_wrap   = 1'b0;
      case (mode)
         c_mode_count: begin
            if (en) begin
               if (up_dn) begin
                  if ((r_q == c_max) || w_q_oor) begin
                     w_q_next = '0;
                     w_wrap   = 1'b1;
                  end else begin
                     w_q_next = r_q + WIDTH'(1);
                  end
               end else begin
                  if (r_q == '0) begin
                     w_q_next = c_max;
                     w_wrap   = 1'b1;
                  end else if (w_q_oor) begin
                     // Out-of-range values snap back into range without a wrap.
                     w_q_next = c_max;
                  end else begin
                     w_q_next = r_q - WIDTH'(1);
                  end
               end
            end
         end
         c_mode_toggle: begin
            if (en) begin
               w_q_next = r_q ^ t_vec;
            end
         end
         c_mode_load: begin
            w_q_next = w_load_oor ? c_max : load_val;
         end
         c_mode_hold: begin
            w_q_next = r_q;
         end
         default: begin
            w_q_next = r_q;
         end
      endcase
   end

   // State register: synchronous active-low reset, wrap sets ovf ahead of clear.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_q   <= c_reset;
         r_tc  <= 1'b0;
         r_ovf <= 1'b0;
      end else begin
         r_q  <= w_q_next;
         r_tc <= w_wrap;
         if (w_wrap) begin
            r_ovf <= 1'b1;
         end else if (ovf_clr) begin
            r_ovf <= 1'b0;
         end
      end
   end

   assign q   = r_q;
   assign tc  = r_tc;
   assign ovf = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_tff_mod_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_tff_mod_counter
// Brief    : Directed table-driven bench for tff_mod_counter (WIDTH=4,
//            MODULUS=10), with side instances for RESET_VAL=3 and MODULUS=16.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tff_mod_counter;

   localparam int WIDTH = 4;

   typedef struct {
      logic             reset_n;
      logic [1:0]       mode;
      logic             en;
      logic             up_dn;
      logic [WIDTH-1:0] t_vec;
      logic [WIDTH-1:0] load_val;
      logic             ovf_clr;
      logic [WIDTH-1:0] exp_q;
      logic             exp_tc;
      logic             exp_ovf;
   } vec_t;

   logic             clk = 1'b0;
   logic             reset_n = 1'b0;
   logic             en = 1'b0;
   logic [1:0]       mode = 2'b00;
   logic             up_dn = 1'b1;
   logic [WIDTH-1:0] t_vec = '0;
   logic [WIDTH-1:0] load_val = '0;
   logic             ovf_clr = 1'b0;

   logic [WIDTH-1:0] q,   q3,   q16;
   logic             tc,  tc3,  tc16;
   logic             ovf, ovf3, ovf16;

   int errors = 0;
   int checks = 0;
   vec_t vecs[$];

   always #5 clk = ~clk;

   tff_mod_counter #(.WIDTH(WIDTH), .MODULUS(10), .RESET_VAL(0)) dut (
      .clk(clk), .reset_n(reset_n), .en(en), .mode(mode), .up_dn(up_dn),
      .t_vec(t_vec), .load_val(load_val), .ovf_clr(ovf_clr),
      .q(q), .tc(tc), .ovf(ovf));

   tff_mod_counter #(.WIDTH(WIDTH), .MODULUS(10), .RESET_VAL(3)) dut_rv3 (
      .clk(clk), .reset_n(reset_n), .en(en), .mode(mode), .up_dn(up_dn),
      .t_vec(t_vec), .load_val(load_val), .ovf_clr(ovf_clr),
      .q(q3), .tc(tc3), .ovf(ovf3));

   tff_mod_counter #(.WIDTH(WIDTH), .MODULUS(16), .RESET_VAL(0)) dut_m16 (
      .clk(clk), .reset_n(reset_n), .en(en), .mode(mode), .up_dn(up_dn),
      .t_vec(t_vec), .load_val(load_val), .ovf_clr(ovf_clr),
      .q(q16), .tc(tc16), .ovf(ovf16));

   task automatic check(input string name, input int idx, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s [%0d]: got %0d, expected %0d", name, idx, act, exp);
      end
   endtask

   task automatic add(input logic rn, input logic [1:0] md, input logic e, input logic ud,
                      input logic [3:0] t, input logic [3:0] lv, input logic clr,
                      input logic [3:0] eq, input logic etc, input logic eo);
      vec_t v;
      v.reset_n = rn; v.mode = md; v.en = e; v.up_dn = ud; v.t_vec = t;
      v.load_val = lv; v.ovf_clr = clr; v.exp_q = eq; v.exp_tc = etc; v.exp_ovf = eo;
      vecs.push_back(v);
   endtask

   // Drive at the falling edge, sample 1 time unit after the rising edge.
   task automatic step(input logic rn, input logic [1:0] md, input logic e, input logic ud,
                       input logic [3:0] t, input logic [3:0] lv, input logic clr);
      @(negedge clk);
      reset_n = rn; mode = md; en = e; up_dn = ud; t_vec = t; load_val = lv; ovf_clr = clr;
      @(posedge clk);
      #1;
   endtask

   initial begin
      // reset mid-count, then count
      add(0, 2'b01, 1, 1, 4'h0, 4'h0, 0, 4'd0, 0, 0);
      add(1, 2'b01, 1, 1, 4'h0, 4'h0, 0, 4'd1, 0, 0);
      add(1, 2'b01, 1, 1, 4'h0, 4'h0, 0, 4'd2, 0, 0);
      // up wrap from 0
      add(1, 2'b11, 0, 1, 4'h0, 4'h0, 0, 4'd0, 0, 0);
      for (int i = 1; i <= 9; i++)
         add(1, 2'b01, 1, 1, 4'h0, 4'h0, 0, 4'(i), 0, 0);
      add(1, 2'b01, 1, 1, 4'h0, 4'h0, 0, 4'd0, 1, 1);
      add(1, 2'b01, 1, 1, 4'h0, 4'h0, 0, 4'd1, 0, 1);
      // hold ignores en
      add(1, 2'b00, 1, 1, 4'hF, 4'h7, 0, 4'd1, 0, 1);
      // down wrap, clear, disabled count, set-wins
      add(1, 2'b11, 0, 0, 4'h0, 4'h0, 0, 4'd0, 0, 1);
      add(1, 2'b01, 1, 0, 4'h0, 4'h0, 0, 4'd9, 1, 1);
      add(1, 2'b01, 1, 0, 4'h0, 4'h0, 1, 4'd8, 0, 0);
      add(1, 2'b01, 0, 0, 4'h0, 4'h0, 0, 4'd8, 0, 0);
      add(1, 2'b11, 0, 0, 4'h0, 4'h0, 0, 4'd0, 0, 0);
      add(1, 2'b01, 1, 0, 4'h0, 4'h0, 1, 4'd9, 1, 1);
      // toggle
      add(1, 2'b11, 0, 0, 4'h0, 4'h5, 0, 4'h5, 0, 1);
      add(1, 2'b10, 1, 0, 4'h3, 4'h0, 0, 4'h6, 0, 1);
      add(1, 2'b10, 0, 0, 4'hF, 4'h0, 0, 4'h6, 0, 1);
      add(1, 2'b10, 1, 0, 4'hF, 4'h0, 0, 4'h9, 0, 1);
      // load saturation and out-of-range count
      add(1, 2'b11, 0, 0, 4'h0, 4'hE, 0, 4'd9, 0, 1);
      add(1, 2'b00, 0, 0, 4'h0, 4'h0, 1, 4'd9, 0, 0);
      add(1, 2'b10, 1, 0, 4'h5, 4'h0, 0, 4'hC, 0, 0);
      add(1, 2'b01, 1, 1, 4'h0, 4'h0, 0, 4'd0, 1, 1);
      add(1, 2'b10, 1, 0, 4'hC, 4'h0, 1, 4'hC, 0, 0);
      add(1, 2'b01, 1, 0, 4'h0, 4'h0, 0, 4'd9, 0, 0);
      add(1, 2'b11, 0, 0, 4'h0, 4'hA, 0, 4'd9, 0, 0);
      add(1, 2'b11, 1, 0, 4'h0, 4'h8, 0, 4'd8, 0, 0);
      // reset on a LOAD 5 edge
      add(1, 2'b01, 1, 0, 4'h0, 4'h0, 0, 4'd7, 0, 0);
      add(0, 2'b11, 1, 0, 4'h0, 4'h5, 0, 4'd0, 0, 0);
      // reset on a wrap edge
      add(1, 2'b11, 0, 1, 4'h0, 4'h9, 0, 4'd9, 0, 0);
      add(0, 2'b01, 1, 1, 4'h0, 4'h0, 0, 4'd0, 0, 0);

      foreach (vecs[i]) begin
         step(vecs[i].reset_n, vecs[i].mode, vecs[i].en, vecs[i].up_dn,
              vecs[i].t_vec, vecs[i].load_val, vecs[i].ovf_clr);
         check("q",   i, int'(q),   int'(vecs[i].exp_q));
         check("tc",  i, int'(tc),  int'(vecs[i].exp_tc));
         check("ovf", i, int'(ovf), int'(vecs[i].exp_ovf));
      end

      // RESET_VAL = 3 instance: reset value then count from it
      step(0, 2'b01, 1, 1, 4'h0, 4'h0, 0);
      check("rv3_q_reset", 0, int'(q3), 3);
      check("rv3_ovf_reset", 0, int'(ovf3), 0);
      step(1, 2'b01, 1, 1, 4'h0, 4'h0, 0);
      check("rv3_q_count", 1, int'(q3), 4);

      // MODULUS = 16 instance: natural wrap at all-ones and zero, no saturation
      step(1, 2'b11, 0, 1, 4'h0, 4'hF, 0);
      check("m16_load", 0, int'(q16), 15);
      check("m10_load_sat", 0, int'(q), 9);
      step(1, 2'b01, 1, 1, 4'h0, 4'h0, 0);
      check("m16_up_q", 1, int'(q16), 0);
      check("m16_up_tc", 1, int'(tc16), 1);
      check("m10_up_q", 1, int'(q), 0);
      check("m10_up_tc", 1, int'(tc), 1);
      step(1, 2'b01, 1, 0, 4'h0, 4'h0, 0);
      check("m16_dn_q", 2, int'(q16), 15);
      check("m16_dn_tc", 2, int'(tc16), 1);
      check("m16_ovf", 2, int'(ovf16), 1);
      check("m10_dn_q", 2, int'(q), 9);
      check("m10_dn_tc", 2, int'(tc), 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
